dac_sample_sequencer: RTL and testbench

- Paced sample feeder for the audio DAC (handshake receiver + PWM).
- Buffers 12-bit duty-cycle samples written by the core's MMIO path in a small FIFO.
- Issues one sample per programmable sample period to the DAC over a four-phase req/ack handshake.
- Reports buffer level and sticky underrun/missed-tick flags for software.

---
 rtl/dac_sample_sequencer_pkg.sv | 14 +
 rtl/dac_sample_sequencer_fifo.sv | 65 ++++++
 rtl/dac_sample_sequencer.sv | 129 ++++++++++++
 tb/tb_dac_sample_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_sample_sequencer_pkg.sv
// Shared constants and handshake state encoding for the DAC sample sequencer.
package dac_sample_sequencer_pkg;

    // Duty-cycle sample width expected by the audio DAC.
    localparam int DAC_DUTY_W = 12;

    // Four-phase handshake states towards the DAC.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_e;

endpackage

// File: rtl/dac_sample_sequencer_fifo.sv
// Synchronous single-clock FIFO with exact occupancy count and head-of-queue
// read data (first-word-fall-through), used to buffer DAC samples.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push, pop;

    // Full/empty come from the registered level only, so a pop never frees a
    // slot for a write in the same cycle and a fresh write is not poppable yet.
    always_comb begin
        full     = (level_q == (AW+1)'(DEPTH));
        empty    = (level_q == '0);
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end
        rd_data  = mem_q[rd_ptr_q];
        level    = level_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paced sample feeder: buffers MMIO-written duty samples and hands one to the
// DAC per sample period over a four-phase req/ack handshake.
module dac_sample_sequencer
    import dac_sample_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int DUTY_W     = DAC_DUTY_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              rate_div,
    input  logic                          wr_valid,
    input  logic [DUTY_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clear_flags,
    output logic                          underrun,
    output logic                          missed_tick,
    output logic                          busy,
    output logic [DUTY_W-1:0]             dac_duty,
    output logic                          dac_req,
    input  logic                          dac_ack
);

    logic [DIV_W-1:0]  count_q, count_d;
    hs_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              underrun_q, underrun_d;
    logic              missed_q, missed_d;
    logic              tick, pop;
    logic              underrun_set, missed_set;
    logic              fifo_full, fifo_empty;
    logic [DUTY_W-1:0] fifo_head;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DUTY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sample-period divider; >= compare so lowering rate_div mid-count ticks
    // immediately instead of wrapping through the whole counter range.
    always_comb begin
        tick    = enable && (count_q >= rate_div);
        count_d = (enable && !tick) ? count_q + DIV_W'(1) : '0;
    end

    // Handshake FSM plus sticky flag update (set wins over clear).
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        duty_d       = duty_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        missed_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        duty_d  = fifo_head;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            REQ: begin
                missed_set = tick;
                if (dac_ack) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                missed_set = tick;
                if (!dac_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        underrun_d = underrun_set | (underrun_q & ~clear_flags);
        missed_d   = missed_set   | (missed_q   & ~clear_flags);
    end

    // State, request, held sample and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            duty_q     <= '0;
            underrun_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            state_q    <= state_d;
            req_q      <= req_d;
            duty_q     <= duty_d;
            underrun_q <= underrun_d;
            missed_q   <= missed_d;
        end
    end

    assign wr_ready    = !fifo_full;
    assign busy        = (state_q != IDLE);
    assign dac_req     = req_q;
    assign dac_duty    = duty_q;
    assign underrun    = underrun_q;
    assign missed_tick = missed_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer with a small DAC ack model.
module tb_dac_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] rate_div;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [4:0]  fifo_level;
    logic        clear_flags;
    logic        underrun;
    logic        missed_tick;
    logic        busy;
    logic [11:0] dac_duty;
    logic        dac_req;
    logic        dac_ack;

    int errors = 0;
    int checks = 0;

    logic [11:0] cap[$];
    int          ack_delay = 2;
    int          ack_cnt   = 0;
    logic        mon_prev  = 1'b0;

    always #5 clk = ~clk;

    dac_sample_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rate_div    (rate_div),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .fifo_level  (fifo_level),
        .clear_flags (clear_flags),
        .underrun    (underrun),
        .missed_tick (missed_tick),
        .busy        (busy),
        .dac_duty    (dac_duty),
        .dac_req     (dac_req),
        .dac_ack     (dac_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    // DAC model: ack ack_delay cycles after req rises, drop ack once req drops;
    // also captures every sample presented on a req rising edge.
    initial begin
        dac_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (dac_req && !mon_prev) cap.push_back(dac_duty);
            mon_prev = dac_req;
            if (dac_req && !dac_ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) dac_ack = 1'b1;
            end else if (!dac_req && dac_ack) begin
                dac_ack = 1'b0;
                ack_cnt = 0;
            end else if (!dac_req) begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        int   n;
        logic p_req;
        logic done;

        rst = 1'b1; enable = 1'b0; rate_div = 16'd9; wr_valid = 1'b0;
        wr_data = '0; clear_flags = 1'b0;
        step(2);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_req", dac_req, 0);
        chk("rst_duty", dac_duty, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {underrun, missed_tick}, 0);
        rst = 1'b0;
        step();

        // Paced delivery at rate_div=9, then underrun on empty FIFO.
        ack_delay = 2;
        wr(12'h100); wr(12'h200); wr(12'h300);
        chk("t1_level3", fifo_level, 3);
        enable = 1'b1;
        n = 0; p_req = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            step();
            if (dac_req && !p_req) begin
                if (n < 3) begin
                    chk("t1_rise_cycle", k, 10 * (n + 1));
                    chk("t1_duty", dac_duty, 12'h100 * (n + 1));
                    chk("t1_level", fifo_level, 2 - n);
                end
                n++;
            end
            p_req = dac_req;
            if (k == 39) chk("t1_no_underrun_yet", underrun, 0);
        end
        chk("t1_rises", n, 3);
        chk("t2_underrun", underrun, 1);
        chk("t2_no_req", dac_req, 0);
        chk("t2_duty_hold", dac_duty, 12'h300);
        chk("t2_busy", busy, 0);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("t2_cleared", underrun, 0);

        // Clear in the same cycle as an underrun tick: set wins.
        enable = 1'b0; rate_div = 16'd0; step();
        enable = 1'b1; clear_flags = 1'b1; step();
        enable = 1'b0; clear_flags = 1'b0;
        chk("t6_set_wins", underrun, 1);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("t6_cleared", underrun, 0);

        // rate_div=0 with slow ack: missed ticks, no loss or duplication.
        ack_delay = 4;
        for (int i = 0; i < 8; i++) wr(12'hA00 + 12'(i));
        chk("t3_level8", fifo_level, 8);
        cap.delete();
        enable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (cap.size() == 8 && !busy) done = 1'b1;
        end
        enable = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_missed", missed_tick, 1);
        chk("t3_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("t3_sample", cap[i], 12'hA00 + 12'(i));
        chk("t3_level0", fifo_level, 0);
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        chk("t3_flags_clr", {underrun, missed_tick}, 0);

        // Fill to full with divider stopped, overflow write ignored, then drain.
        ack_delay = 1; rate_div = 16'd3;
        for (int i = 0; i < 15; i++) wr(12'h500 + 12'(i));
        chk("t4_ready15", wr_ready, 1);
        wr(12'h50F);
        chk("t4_ready_full", wr_ready, 0);
        chk("t4_level16", fifo_level, 16);
        wr(12'hFFF);
        chk("t4_level_ovf", fifo_level, 16);
        cap.delete();
        enable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (cap.size() == 16 && !busy) done = 1'b1;
        end
        enable = 1'b0;
        step(4);
        chk("t4_done", done, 1);
        chk("t4_count", cap.size(), 16);
        for (int i = 0; i < 16 && i < cap.size(); i++) chk("t4_sample", cap[i], 12'h500 + 12'(i));
        chk("t4_level0", fifo_level, 0);
        chk("t4_ready", wr_ready, 1);

        // Reset while a handshake is stuck in REQ.
        ack_delay = 1000; rate_div = 16'd0;
        wr(12'h777); wr(12'h778);
        enable = 1'b1;
        for (int i = 0; i < 20 && !dac_req; i++) step();
        chk("t5_req", dac_req, 1);
        step(3);
        chk("t5_missed", missed_tick, 1);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("t5_req_drop", dac_req, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_flags", {underrun, missed_tick}, 0);
        chk("t5_busy_clr", busy, 0);
        chk("t5_duty", dac_duty, 0);
        chk("t5_wr_ready", wr_ready, 1);
        rst = 1'b0; enable = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
